// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV flag bit positions and datapath width.
package cpu_pkg;

    localparam int DATA_W = 32;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check against an NZCV flag vector.
module cond_eval
    import cpu_pkg::*;
(
    input  logic  [3:0] flags,
    input  cond_e       cond,
    output logic        ok
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        ok = 1'b0;
        case (cond)
            EQ: ok = w_z;
            NE: ok = !w_z;
            CS: ok = w_c;
            CC: ok = !w_c;
            MI: ok = w_n;
            PL: ok = !w_n;
            VS: ok = w_v;
            VC: ok = !w_v;
            HI: ok = w_c && !w_z;
            LS: ok = !w_c || w_z;
            GE: ok = (w_n == w_v);
            LT: ok = (w_n != w_v);
            GT: ok = !w_z && (w_n == w_v);
            LE: ok = w_z || (w_n != w_v);
            AL: ok = 1'b1;
            NV: ok = 1'b0;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with conditional execution, committed NZCV flags
// and a committed-instruction counter.
module ex_mem_register
    import cpu_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] resultado,
    input  logic [3:0]   flagsResult,
    input  logic [3:0]   rd,
    input  cond_e        cond,
    input  logic         set_flags,
    input  logic         reg_wr,
    input  logic         mem_wr,
    input  logic         mem_rd,
    input  logic         is_branch,
    input  logic         stall,
    input  logic         flush,
    output logic         valid_q,
    output logic         reg_wr_q,
    output logic         mem_wr_q,
    output logic         mem_rd_q,
    output logic         branch_taken_q,
    output logic [N-1:0] result_q,
    output logic [3:0]   rd_q,
    output logic [3:0]   flags_q,
    output logic [31:0]  instr_count
);

    logic         r_valid;
    logic         r_regWr;
    logic         r_memWr;
    logic         r_memRd;
    logic         r_branchTaken;
    logic [N-1:0] r_result;
    logic [3:0]   r_rd;
    logic [3:0]   r_flags;
    logic [31:0]  r_instrCount;
    logic         w_condOk;

    // Condition looks only at committed flags, so the previous instruction's
    // flag update is visible here without any forwarding path.
    cond_eval u_condEval (
        .flags (r_flags),
        .cond  (cond),
        .ok    (w_condOk)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_regWr       <= 1'b0;
            r_memWr       <= 1'b0;
            r_memRd       <= 1'b0;
            r_branchTaken <= 1'b0;
            r_result      <= '0;
            r_rd          <= '0;
            r_flags       <= '0;
            r_instrCount  <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            r_valid       <= 1'b0;
            r_regWr       <= 1'b0;
            r_memWr       <= 1'b0;
            r_memRd       <= 1'b0;
            r_branchTaken <= 1'b0;
        end else if (!stall) begin
            r_valid       <= 1'b1;
            r_regWr       <= reg_wr && w_condOk;
            r_memWr       <= mem_wr && w_condOk;
            r_memRd       <= mem_rd && w_condOk;
            r_branchTaken <= is_branch && w_condOk;
            r_result      <= resultado;
            r_rd          <= rd;
            if (set_flags && w_condOk) begin
                r_flags <= flagsResult;
            end
            if (w_condOk) begin
                r_instrCount <= r_instrCount + 32'd1;
            end
        end
    end

    assign valid_q        = r_valid;
    assign reg_wr_q       = r_regWr;
    assign mem_wr_q       = r_memWr;
    assign mem_rd_q       = r_memRd;
    assign branch_taken_q = r_branchTaken;
    assign result_q       = r_result;
    assign rd_q           = r_rd;
    assign flags_q        = r_flags;
    assign instr_count    = r_instrCount;

endmodule
